// File: rtl/ub_ctrl.sv
// Unified-buffer sequencer: writes SIZE array rows per tile, then streams
// all SIZE*SIZE entries to the host over a valid/ready handshake.
module ub_ctrl #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = $clog2(SIZE*SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sa_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);

    localparam int ROW_W = $clog2(SIZE);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE*SIZE - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, DONE} state_t;

    state_t            state, state_nxt;
    logic [ROW_W-1:0]  row_cnt, row_cnt_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
            rd_addr <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
            rd_addr <= rd_addr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        rd_addr_nxt = rd_addr;
        wr_en       = 1'b0;
        rd_valid    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt   = WRITE;
                    row_cnt_nxt = '0;
                    rd_addr_nxt = '0;
                end
            end
            WRITE: begin
                wr_en = sa_valid;
                if (sa_valid) begin
                    // Last row holds the counter; it is cleared on the way back to IDLE.
                    if (row_cnt == LAST_ROW) state_nxt = WAIT;
                    else                     row_cnt_nxt = row_cnt + ROW_W'(1);
                end
            end
            WAIT: begin
                state_nxt = READ;
            end
            READ: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (rd_addr == LAST_ADDR) state_nxt = DONE;
                    else                      rd_addr_nxt = rd_addr + ADDR_W'(1);
                end
            end
            DONE: begin
                done        = 1'b1;
                state_nxt   = IDLE;
                row_cnt_nxt = '0;
                rd_addr_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Abort outranks every other transition, including start.
        if (abort) begin
            state_nxt   = IDLE;
            row_cnt_nxt = '0;
            rd_addr_nxt = '0;
        end
    end

    assign wr_addr = ADDR_W'({row_cnt, {ROW_W{1'b0}}});
    assign rd_last = (state == READ) && (rd_addr == LAST_ADDR);

endmodule

// File: tb/tb_ub_ctrl.sv
// Directed self-checking bench for ub_ctrl: nominal tile, write stall,
// read backpressure, abort, ignored inputs and asynchronous reset.
module tb_ub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, sa_valid, rd_ready;
    logic       wr_en, rd_valid, rd_last, busy, done;
    logic [5:0] wr_addr, rd_addr;

    int tests = 0;
    int fails = 0;

    ub_ctrl #(.SIZE(8), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sa_valid(sa_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_last(rd_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step to 2 time units after the next rising edge; inputs are driven here.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"},    wr_en,    0);
        chk({tag, "_wr_addr"},  wr_addr,  0);
        chk({tag, "_rd_addr"},  rd_addr,  0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_last"},  rd_last,  0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_done"},     done,     0);
    endtask

    // Full best-case tile starting from IDLE; noisy keeps start and sa_valid
    // high in states where they must be ignored.
    task automatic nominal_tile(input bit noisy);
        start = 1'b1; sa_valid = noisy; rd_ready = 1'b1; abort = 1'b0;
        #1;
        chk("c0_busy",  busy,  0);
        chk("c0_wr_en", wr_en, 0);
        for (int i = 0; i < 8; i++) begin
            nxt();
            start = noisy; sa_valid = 1'b1;
            #1;
            chk("wr_en",   wr_en,   1);
            chk("wr_addr", wr_addr, i * 8);
            chk("wr_busy", busy,    1);
            chk("wr_rd_valid", rd_valid, 0);
        end
        nxt();
        #1;
        chk("wait_wr_en",    wr_en,    0);
        chk("wait_rd_valid", rd_valid, 0);
        chk("wait_busy",     busy,     1);
        for (int k = 0; k < 64; k++) begin
            nxt();
            #1;
            chk("rd_valid",   rd_valid, 1);
            chk("rd_addr",    rd_addr,  k);
            chk("rd_last",    rd_last,  (k == 63) ? 1 : 0);
            chk("rd_wr_en",   wr_en,    0);
            chk("rd_done",    done,     0);
        end
        nxt();
        #1;
        chk("c74_done",     done,     1);
        chk("c74_busy",     busy,     1);
        chk("c74_rd_valid", rd_valid, 0);
        nxt();
        start = 1'b0; sa_valid = noisy;
        #1;
        chk("c75_done",    done,    0);
        chk("c75_busy",    busy,    0);
        chk("c75_wr_en",   wr_en,   0);
        chk("c75_rd_addr", rd_addr, 0);
        chk("c75_wr_addr", wr_addr, 0);
        nxt();
        sa_valid = 1'b0;
        #1;
        chk("c76_busy", busy, 0);
    endtask

    // Runs a clean tile up to READ cycle 40 (rd_addr 30), leaving time at +3.
    task automatic run_to_cycle40();
        start = 1'b1; sa_valid = 1'b1; rd_ready = 1'b1; abort = 1'b0;
        nxt();
        start = 1'b0;
        repeat (39) nxt();
        #1;
        chk("c40_rd_addr", rd_addr, 30);
    endtask

    initial begin
        int  nw;
        int  exp_addr;
        int  hold;
        bit  done_seen;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sa_valid = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        nxt();
        #1;
        chk("post_rst_busy", busy, 0);
        nxt();

        // Nominal tile.
        nominal_tile(1'b0);
        nxt();

        // Write stall with alternating sa_valid, then read backpressure at 17.
        start = 1'b1; sa_valid = 1'b0; rd_ready = 1'b0;
        nxt();
        start = 1'b0;
        nw = 0;
        for (int c = 0; c < 16; c++) begin
            sa_valid = (c % 2 == 0) || (c == 15);
            #1;
            chk("stall_wr_en", wr_en, (c % 2 == 0) ? 1 : 0);
            if (wr_en === 1'b1) begin
                chk("stall_wr_addr", wr_addr, nw * 8);
                nw++;
            end
            nxt();
        end
        sa_valid = 1'b0;
        exp_addr = 0;
        hold = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 90 && !done_seen; c++) begin
            if (exp_addr == 17 && hold < 5) begin
                rd_ready = 1'b0;
                hold++;
            end else begin
                rd_ready = 1'b1;
            end
            #1;
            chk("bp_rd_valid", rd_valid, 1);
            chk("bp_rd_addr",  rd_addr,  exp_addr);
            chk("bp_rd_last",  rd_last,  (exp_addr == 63) ? 1 : 0);
            if (rd_ready) begin
                if (exp_addr == 63) done_seen = 1'b1;
                else                exp_addr++;
            end
            nxt();
        end
        #1;
        chk("bp_done", done, 1);
        nxt();
        #1;
        chk("bp_idle_busy", busy, 0);
        nxt();

        // Abort in the middle of readback.
        run_to_cycle40();
        abort = 1'b1;
        nxt();
        abort = 1'b0;
        #1;
        chk("abort_busy",     busy,     0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_done",     done,     0);
        chk("abort_rd_addr",  rd_addr,  0);
        repeat (3) begin
            nxt();
            #1;
            chk("abort_no_done", done, 0);
            chk("abort_idle",    busy, 0);
        end
        nxt();
        nominal_tile(1'b0);
        nxt();

        // Asynchronous reset mid-tile.
        run_to_cycle40();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        nxt();
        rst_n = 1'b1;
        start = 1'b0;
        nxt();
        #1;
        chk("arst_rel_busy",  busy,  0);
        chk("arst_rel_wr_en", wr_en, 0);
        nxt();
        #1;
        chk("arst_rel2_busy", busy, 0);
        nxt();

        // Ignored start/sa_valid while busy or idle; same tile timing.
        nominal_tile(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ub_ctrl.md
# ub_ctrl

Sequencing controller for the 8x8 unified buffer that sits between the systolic array output and the host readback path. For each tile it accepts SIZE deskewed partial-sum rows from the array and issues one SIZE-wide buffer write per row at consecutive row base addresses. It then streams all SIZE*SIZE rounded activations back out through a valid/ready handshake and signals tile completion.

## Interface
Parameters:
- SIZE, 8, systolic array dimension; rows per tile and entries per row
- ADDR_W, $clog2(SIZE*SIZE) = 6, buffer address width

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  begin a tile; honoured only in IDLE, ignored otherwise
- abort  in  1  synchronous abort; returns to IDLE from any state next edge
- sa_valid  in  1  array presents one complete deskewed row this cycle
- wr_en  out  1  buffer write strobe (writes SIZE entries at wr_addr..wr_addr+SIZE-1)
- wr_addr  out  ADDR_W  row base address = row_cnt*SIZE
- rd_addr  out  ADDR_W  buffer read address; read data is combinational from it
- rd_valid  out  1  buffer read data at rd_addr is valid for the host
- rd_ready  in  1  host accepts the current read word
- rd_last  out  1  current read word is entry SIZE*SIZE-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile completion

## Operation
- FSM states: IDLE, WRITE, WAIT, READ, DONE.
- IDLE: start=1 -> WRITE; row_cnt<=0, rd_addr<=0.
- WRITE: wr_en = sa_valid, combinational. wr_addr = {row_cnt, log2(SIZE) zero bits}. Each cycle with sa_valid, row_cnt++. When sa_valid is accepted with row_cnt==SIZE-1 -> WAIT. sa_valid=0 stalls indefinitely with no write.
- WAIT: one cycle with no strobes, so the final row is committed before readback -> READ.
- READ: rd_valid=1. A transfer happens when rd_valid&&rd_ready; then rd_addr++. rd_last = (rd_addr==SIZE*SIZE-1). A transfer with rd_last=1 -> DONE. rd_ready=0 holds rd_addr and keeps rd_valid high (no drop while waiting).
- DONE: done=1 for exactly one cycle -> IDLE. start in DONE is ignored.
- abort, any state: next state IDLE, counters cleared, no further wr_en or rd_valid. abort has priority over start and over every transition.
- sa_valid outside WRITE is ignored and never produces wr_en.
- row_cnt counts 0..SIZE-1 and never wraps inside a tile. rd_addr spans 0..SIZE*SIZE-1 and is cleared on entry to IDLE, not by wrap.

## Timing
- Reset values: state IDLE, wr_en 0, wr_addr 0, rd_addr 0, rd_valid 0, rd_last 0, busy 0, done 0.
- All outputs except wr_en are registered or decoded from registered state. wr_en is state-gated sa_valid, with zero-cycle latency.
- Best-case tile (sa_valid and rd_ready held high, start in cycle 0):
  - WRITE in cycles 1-8, with writes at 0,8,...,56
  - WAIT in cycle 9
  - READ in cycles 10-73, with rd_addr 0..63
  - DONE in cycle 74 (done=1)
  - IDLE in cycle 75
  - busy is high in cycles 1-74.
- A new start is accepted earliest in the cycle after DONE.
- rst_n low mid-tile immediately forces the reset values, asynchronously. The first edge after release stays in IDLE unless start is high.

## Test plan
- Nominal tile: start pulse, sa_valid high 8 cycles, rd_ready high -> wr_addr 0,8,..,56 in cycles 1-8, rd_addr 0..63 in cycles 10-73, rd_last only at 63, done in cycle 74.
- Write stall: sa_valid toggled 1,0,1,0,... -> wr_en only on sa_valid cycles, exactly 8 writes, WAIT entered after the 8th.
- Read backpressure: rd_ready low for 5 cycles at rd_addr=17 -> rd_addr holds 17 and rd_valid stays 1; read resumes at 18 with no skipped or duplicated address.
- Abort mid-read at rd_addr=30 -> IDLE next cycle, busy=0, rd_valid=0, no done pulse. A following start runs a full tile from wr_addr 0.
- Ignored inputs: start while busy, and sa_valid in IDLE/READ -> no state change and no wr_en. Tile completes with the same cycle count as nominal.
- Async reset at cycle 40 of a tile -> all outputs at reset values within the same cycle, before the next edge; the controller stays IDLE after release until start.
